// File: rtl/mem_pkg.sv
// Shared MCB command definitions: instruction codes, word geometry and
// the command arbiter's state encoding.
package mem_pkg;

   localparam logic [2:0] MCB_INSTR_WR   = 3'b000;
   localparam logic [2:0] MCB_INSTR_RD   = 3'b001;
   localparam int         BYTES_PER_WORD = 8;
   localparam int         ALIGN_W        = $clog2(BYTES_PER_WORD);
   localparam int         RD_DEPTH_DEF   = 64;

   // Requester index used by the arbiter: bit 0 is the writer, bit 1 the reader.
   localparam logic SEL_WR = 1'b0;
   localparam logic SEL_RD = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is chosen; the history register moves only when a grant is taken.
module rr_arb2
   import mem_pkg::*;
(
   input  logic       mem_clk,
   input  logic       fsm_rst,
   input  logic [1:0] elig,
   input  logic       advance,
   output logic       sel,
   output logic       valid
);

   logic r_last;

   always_ff @(posedge mem_clk or posedge fsm_rst) begin
      if (fsm_rst)
         r_last <= SEL_RD;
      else if (advance)
         r_last <= sel;
   end

   always_comb begin
      valid = |elig;
      if (&elig)
         sel = ~r_last;
      else
         sel = elig[1];
   end

endmodule

// File: rtl/mcb_cmd_arbiter.sv
// Shares the MCB command port between the pattern-write and pattern-read
// engines, gating writes on FIFO data and reads on reserved read-FIFO space.
module mcb_cmd_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 30,
   parameter int BL_W     = 6,
   parameter int RD_DEPTH = RD_DEPTH_DEF,
   parameter int CNT_W    = 7
) (
   input  logic              mem_clk,
   input  logic              fsm_rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BL_W-1:0]   wr_bl,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BL_W-1:0]   rd_bl,
   output logic              rd_gnt,
   input  logic [CNT_W-1:0]  p0_wr_count,
   input  logic              p1_rd_en,
   input  logic              cmd_full,
   output logic              cmd_en,
   output logic [2:0]        cmd_instr,
   output logic [BL_W-1:0]   cmd_bl,
   output logic [ADDR_W-1:0] cmd_byte_addr,
   output logic [CNT_W-1:0]  rd_credit,
   output logic              busy,
   output logic              err_misalign,
   output logic              err_credit
);

   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(RD_DEPTH);

   arb_state_t        r_state, w_state_nxt;
   logic [1:0]        w_elig;
   logic              w_sel, w_valid, w_take;
   logic              r_sel;
   logic [BL_W-1:0]   r_bl;
   logic [ADDR_W-1:0] r_addr;
   logic              w_misalign, w_rd_reserve;
   logic [CNT_W-1:0]  r_credit;
   logic              r_err_credit;
   logic [CNT_W:0]    w_credit_sum;

   // Burst length field is words-1; widen one bit so a 64-word burst compares cleanly.
   function automatic logic [CNT_W:0] burst_words(input logic [BL_W-1:0] bl);
      return {{(CNT_W+1-BL_W){1'b0}}, bl} + (CNT_W+1)'(1);
   endfunction

   function automatic logic [CNT_W-1:0] credit_sat(input logic [CNT_W:0] sum);
      return (sum > DEPTH_EXT) ? CNT_W'(RD_DEPTH) : sum[CNT_W-1:0];
   endfunction

   assign w_elig[SEL_WR] = wr_req && ({1'b0, p0_wr_count} >= burst_words(wr_bl));
   assign w_elig[SEL_RD] = rd_req && ({1'b0, r_credit} >= burst_words(rd_bl));
   assign w_take         = (r_state == S_IDLE) && !cmd_full && w_valid;

   rr_arb2 u_arb (
      .mem_clk (mem_clk),
      .fsm_rst (fsm_rst),
      .elig    (w_elig),
      .advance (w_take),
      .sel     (w_sel),
      .valid   (w_valid)
   );

   always_ff @(posedge mem_clk) begin
      if (w_take) begin
         r_sel  <= w_sel;
         r_bl   <= (w_sel == SEL_RD) ? rd_bl   : wr_bl;
         r_addr <= (w_sel == SEL_RD) ? rd_addr : wr_addr;
      end
   end

   assign w_misalign   = |r_addr[ALIGN_W-1:0];
   assign w_rd_reserve = (r_state == S_ISSUE) && (r_sel == SEL_RD) && !w_misalign;

   always_ff @(posedge mem_clk or posedge fsm_rst) begin
      if (fsm_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // The guard cycle covers the one-cycle lag of cmd_full behind cmd_en.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_GUARD;
         S_GUARD: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_en        = 1'b0;
      cmd_instr     = 3'b000;
      cmd_bl        = '0;
      cmd_byte_addr = '0;
      wr_gnt        = 1'b0;
      rd_gnt        = 1'b0;
      err_misalign  = 1'b0;
      busy          = (r_state != S_IDLE);
      if (r_state == S_ISSUE) begin
         cmd_en        = !w_misalign;
         cmd_instr     = (r_sel == SEL_RD) ? MCB_INSTR_RD : MCB_INSTR_WR;
         cmd_bl        = r_bl;
         cmd_byte_addr = r_addr;
         wr_gnt        = (r_sel == SEL_WR);
         rd_gnt        = (r_sel == SEL_RD);
         err_misalign  = w_misalign;
      end
   end

   assign w_credit_sum = {1'b0, r_credit} + {{CNT_W{1'b0}}, p1_rd_en}
                       - (w_rd_reserve ? burst_words(r_bl) : '0);

   always_ff @(posedge mem_clk or posedge fsm_rst) begin
      if (fsm_rst) begin
         r_credit     <= CNT_W'(RD_DEPTH);
         r_err_credit <= 1'b0;
      end else begin
         r_credit <= credit_sat(w_credit_sum);
         if (w_credit_sum > DEPTH_EXT)
            r_err_credit <= 1'b1;
      end
   end

   assign rd_credit  = r_credit;
   assign err_credit = r_err_credit;

endmodule
